c2c_tx_framer: RTL and testbench

- Parametrised chip-to-chip link transmit framer. Accepts AXI4 slave AW/W and AR requests and serialises each one into a FLIT_W-bit valid/ready flit stream: header, address flits, then data flits for writes.
- Successor to the single-beat C2C link request path. It adds:
  - full burst forwarding;
  - configurable address, data and flit widths;
  - ID and size fields in the header;
  - round-robin write/read arbitration;
  - w_last protocol checking.
- Sits between the on-chip AXI interconnect and the C2C PHY/serdes. Responses (B/R) are produced by the companion receive block and are out of scope.

---
 rtl/c2c_tx_framer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_c2c_tx_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2c_tx_framer.sv
// c2c_tx_framer
//
// Chip-to-chip link transmit framer. Takes AXI4 write (AW + W) and read (AR)
// requests and turns each into a FLIT_W-bit valid/ready flit stream:
//   header flit, 64/FLIT_W address flits (MS flit first), then for writes
//   DATA_W/FLIT_W flits per beat (MS flit first).
//
// Header flit layout:
//   [15:0]              len (beats-1, zero-extended)
//   [16]                op  (1 = write, 0 = read)
//   [16+ID_W:17]        id
//   [19+ID_W:17+ID_W]   size
//   [31]                strobe framing flag (C2C_STRB_EN builds only)
//   all other bits 0
//
// Build option:
//   C2C_STRB_EN  when defined, every write beat is preceded by one strobe flit
//                (strb zero-extended to FLIT_W) and header bit 31 is set.
//                When undefined, strb is ignored.
//
// Ports:
//   clock                      rising-edge clock
//   reset                      asynchronous active-low reset
//   io_s_axi_aw_*              AXI write-address channel (burst ignored)
//   io_s_axi_w_*               AXI write-data channel
//   io_s_axi_ar_*              AXI read-address channel (burst ignored)
//   io_out_valid/ready/bits    outgoing flit stream
//   io_err_wlast               one-cycle pulse when w_last disagrees with len
//   io_busy                    high whenever a frame is in progress

module c2c_tx_framer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FLIT_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_s_axi_aw_valid,
    output logic                io_s_axi_aw_ready,
    input  logic [ID_W-1:0]     io_s_axi_aw_bits_id,
    input  logic [ADDR_W-1:0]   io_s_axi_aw_bits_addr,
    input  logic [7:0]          io_s_axi_aw_bits_len,
    input  logic [2:0]          io_s_axi_aw_bits_size,
    input  logic [1:0]          io_s_axi_aw_bits_burst,

    input  logic                io_s_axi_w_valid,
    output logic                io_s_axi_w_ready,
    input  logic [DATA_W-1:0]   io_s_axi_w_bits_data,
    input  logic [DATA_W/8-1:0] io_s_axi_w_bits_strb,
    input  logic                io_s_axi_w_bits_last,

    input  logic                io_s_axi_ar_valid,
    output logic                io_s_axi_ar_ready,
    input  logic [ID_W-1:0]     io_s_axi_ar_bits_id,
    input  logic [ADDR_W-1:0]   io_s_axi_ar_bits_addr,
    input  logic [7:0]          io_s_axi_ar_bits_len,
    input  logic [2:0]          io_s_axi_ar_bits_size,
    input  logic [1:0]          io_s_axi_ar_bits_burst,

    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [FLIT_W-1:0]   io_out_bits,

    output logic                io_err_wlast,
    output logic                io_busy
);

    localparam int NUM_ADDR_FLITS = 64 / FLIT_W;
    localparam int NUM_DATA_FLITS = DATA_W / FLIT_W;
    // Enough for up to 4 flits per beat and 2 address flits.
    localparam int FIDX_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_WLOAD,
`ifdef C2C_STRB_EN
        S_STRB,
`endif
        S_DATA
    } state_t;

    state_t              state_reg, state_next;

    logic                pri_write_reg;     // 1: write wins a simultaneous request
    logic                op_reg;
    logic [ID_W-1:0]     id_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [7:0]          len_reg;
    logic [2:0]          size_reg;
    logic [DATA_W-1:0]   beat_reg;
    logic [7:0]          beat_cnt_reg;
    logic [FIDX_W-1:0]   flit_idx_reg;
    logic                err_wlast_reg;
`ifdef C2C_STRB_EN
    logic [DATA_W/8-1:0] strb_reg;
`endif

    logic                grant_write;
    logic                aw_fire, ar_fire, w_fire, out_fire;
    logic                addr_last, data_last, frame_done;
    logic [63:0]         addr_ext;
    logic [FLIT_W-1:0]   hdr_flit;

    // burst is never transmitted; strb only matters in strobe builds.
    logic                unused_burst;
    assign unused_burst = ^{io_s_axi_aw_bits_burst, io_s_axi_ar_bits_burst};
`ifndef C2C_STRB_EN
    logic                unused_strb;
    assign unused_strb = ^io_s_axi_w_bits_strb;
`endif

    // Tie goes to the side not granted last; a lone requester always wins.
    assign grant_write = io_s_axi_aw_valid && (!io_s_axi_ar_valid || pri_write_reg);

    assign aw_fire  = io_s_axi_aw_valid && io_s_axi_aw_ready;
    assign ar_fire  = io_s_axi_ar_valid && io_s_axi_ar_ready;
    assign w_fire   = io_s_axi_w_valid  && io_s_axi_w_ready;
    assign out_fire = io_out_valid      && io_out_ready;

    assign addr_last  = (flit_idx_reg == FIDX_W'(NUM_ADDR_FLITS - 1));
    assign data_last  = (flit_idx_reg == FIDX_W'(NUM_DATA_FLITS - 1));
    assign frame_done = (beat_cnt_reg == len_reg);

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_W-1:0] = addr_reg;
    end

    always_comb begin
        hdr_flit = '0;
        hdr_flit[15:0]        = {8'd0, len_reg};
        hdr_flit[16]          = op_reg;
        hdr_flit[17 +: ID_W]  = id_reg;
        hdr_flit[17+ID_W +: 3] = size_reg;
`ifdef C2C_STRB_EN
        hdr_flit[31]          = 1'b1;
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (aw_fire || ar_fire) state_next = S_HDR;
            S_HDR:   if (io_out_ready) state_next = S_ADDR;
            S_ADDR:  if (io_out_ready && addr_last)
                         state_next = op_reg ? S_WLOAD : S_IDLE;
`ifdef C2C_STRB_EN
            S_WLOAD: if (io_s_axi_w_valid) state_next = S_STRB;
            S_STRB:  if (io_out_ready) state_next = S_DATA;
`else
            S_WLOAD: if (io_s_axi_w_valid) state_next = S_DATA;
`endif
            S_DATA:  if (io_out_ready && data_last)
                         state_next = frame_done ? S_IDLE : S_WLOAD;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        io_s_axi_aw_ready = 1'b0;
        io_s_axi_ar_ready = 1'b0;
        io_s_axi_w_ready  = 1'b0;
        io_out_valid      = 1'b0;
        io_out_bits       = '0;
        case (state_reg)
            S_IDLE: begin
                io_s_axi_aw_ready = grant_write;
                io_s_axi_ar_ready = io_s_axi_ar_valid && !grant_write;
            end
            S_HDR: begin
                io_out_valid = 1'b1;
                io_out_bits  = hdr_flit;
            end
            S_ADDR: begin
                io_out_valid = 1'b1;
                io_out_bits  = addr_ext[(NUM_ADDR_FLITS - 1 - int'(flit_idx_reg)) * FLIT_W +: FLIT_W];
            end
            S_WLOAD: begin
                io_s_axi_w_ready = 1'b1;
            end
`ifdef C2C_STRB_EN
            S_STRB: begin
                io_out_valid = 1'b1;
                io_out_bits[DATA_W/8-1:0] = strb_reg;
            end
`endif
            S_DATA: begin
                io_out_valid = 1'b1;
                io_out_bits  = beat_reg[(NUM_DATA_FLITS - 1 - int'(flit_idx_reg)) * FLIT_W +: FLIT_W];
            end
            default: ;
        endcase
    end

    assign io_busy      = (state_reg != S_IDLE);
    assign io_err_wlast = err_wlast_reg;

    // ------------------------------------------------------------------
    // Request capture, beat/flit counters, w_last checking
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pri_write_reg <= 1'b1;
            op_reg        <= 1'b0;
            id_reg        <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            beat_reg      <= '0;
            beat_cnt_reg  <= '0;
            flit_idx_reg  <= '0;
            err_wlast_reg <= 1'b0;
`ifdef C2C_STRB_EN
            strb_reg      <= '0;
`endif
        end else begin
            err_wlast_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    flit_idx_reg <= '0;
                    beat_cnt_reg <= '0;
                    if (aw_fire) begin
                        op_reg        <= 1'b1;
                        id_reg        <= io_s_axi_aw_bits_id;
                        addr_reg      <= io_s_axi_aw_bits_addr;
                        len_reg       <= io_s_axi_aw_bits_len;
                        size_reg      <= io_s_axi_aw_bits_size;
                        pri_write_reg <= 1'b0;
                    end else if (ar_fire) begin
                        op_reg        <= 1'b0;
                        id_reg        <= io_s_axi_ar_bits_id;
                        addr_reg      <= io_s_axi_ar_bits_addr;
                        len_reg       <= io_s_axi_ar_bits_len;
                        size_reg      <= io_s_axi_ar_bits_size;
                        pri_write_reg <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (out_fire) begin
                        flit_idx_reg <= addr_last ? '0 : flit_idx_reg + FIDX_W'(1);
                    end
                end
                S_WLOAD: begin
                    if (w_fire) begin
                        beat_reg      <= io_s_axi_w_bits_data;
`ifdef C2C_STRB_EN
                        strb_reg      <= io_s_axi_w_bits_strb;
`endif
                        // Flag only; the frame length still follows len_reg.
                        err_wlast_reg <= (io_s_axi_w_bits_last != frame_done);
                    end
                end
                S_DATA: begin
                    if (out_fire) begin
                        if (data_last) begin
                            flit_idx_reg <= '0;
                            if (!frame_done) beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        end else begin
                            flit_idx_reg <= flit_idx_reg + FIDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c2c_tx_framer.sv
module tb_c2c_tx_framer;

    logic        clock = 1'b0;
    logic        reset;

    // 32-bit data instance
    logic        aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready, w_last;
    logic [3:0]  aw_id, ar_id;
    logic [31:0] aw_addr, ar_addr, w_data;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst;
    logic [3:0]  w_strb;
    logic        out_valid, out_ready, err_wlast, busy;
    logic [31:0] out_bits;

    // 64-bit data instance
    logic        aw_valid64, aw_ready64, ar_valid64, ar_ready64, w_valid64, w_ready64, w_last64;
    logic [3:0]  aw_id64, ar_id64;
    logic [31:0] aw_addr64, ar_addr64;
    logic [7:0]  aw_len64, ar_len64;
    logic [2:0]  aw_size64, ar_size64;
    logic [1:0]  aw_burst64, ar_burst64;
    logic [63:0] w_data64;
    logic [7:0]  w_strb64;
    logic        out_valid64, out_ready64, err_wlast64, busy64;
    logic [31:0] out_bits64;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    logic [31:0] flits[$];
    logic [31:0] flits64[$];
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    c2c_tx_framer #(.ADDR_W(32), .DATA_W(32), .FLIT_W(32), .ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .io_s_axi_aw_valid(aw_valid), .io_s_axi_aw_ready(aw_ready),
        .io_s_axi_aw_bits_id(aw_id), .io_s_axi_aw_bits_addr(aw_addr),
        .io_s_axi_aw_bits_len(aw_len), .io_s_axi_aw_bits_size(aw_size),
        .io_s_axi_aw_bits_burst(aw_burst),
        .io_s_axi_w_valid(w_valid), .io_s_axi_w_ready(w_ready),
        .io_s_axi_w_bits_data(w_data), .io_s_axi_w_bits_strb(w_strb),
        .io_s_axi_w_bits_last(w_last),
        .io_s_axi_ar_valid(ar_valid), .io_s_axi_ar_ready(ar_ready),
        .io_s_axi_ar_bits_id(ar_id), .io_s_axi_ar_bits_addr(ar_addr),
        .io_s_axi_ar_bits_len(ar_len), .io_s_axi_ar_bits_size(ar_size),
        .io_s_axi_ar_bits_burst(ar_burst),
        .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_bits(out_bits),
        .io_err_wlast(err_wlast), .io_busy(busy)
    );

    c2c_tx_framer #(.ADDR_W(32), .DATA_W(64), .FLIT_W(32), .ID_W(4)) dut64 (
        .clock(clock), .reset(reset),
        .io_s_axi_aw_valid(aw_valid64), .io_s_axi_aw_ready(aw_ready64),
        .io_s_axi_aw_bits_id(aw_id64), .io_s_axi_aw_bits_addr(aw_addr64),
        .io_s_axi_aw_bits_len(aw_len64), .io_s_axi_aw_bits_size(aw_size64),
        .io_s_axi_aw_bits_burst(aw_burst64),
        .io_s_axi_w_valid(w_valid64), .io_s_axi_w_ready(w_ready64),
        .io_s_axi_w_bits_data(w_data64), .io_s_axi_w_bits_strb(w_strb64),
        .io_s_axi_w_bits_last(w_last64),
        .io_s_axi_ar_valid(ar_valid64), .io_s_axi_ar_ready(ar_ready64),
        .io_s_axi_ar_bits_id(ar_id64), .io_s_axi_ar_bits_addr(ar_addr64),
        .io_s_axi_ar_bits_len(ar_len64), .io_s_axi_ar_bits_size(ar_size64),
        .io_s_axi_ar_bits_burst(ar_burst64),
        .io_out_valid(out_valid64), .io_out_ready(out_ready64), .io_out_bits(out_bits64),
        .io_err_wlast(err_wlast64), .io_busy(busy64)
    );

    // Flit / error monitors, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid && out_ready)     flits.push_back(out_bits);
            if (out_valid64 && out_ready64) flits64.push_back(out_bits64);
            if (err_wlast)                  err_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        bit fired = 1'b0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = 2'b01;
        aw_valid = 1'b1;
        for (int n = 0; n < 200 && !fired; n++) begin
            @(negedge clock);
            fired = aw_ready;
            tick();
        end
        aw_valid = 1'b0;
        check("aw_handshake", 64'(fired), 64'd1);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        bit fired = 1'b0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = 2'b01;
        ar_valid = 1'b1;
        for (int n = 0; n < 200 && !fired; n++) begin
            @(negedge clock);
            fired = ar_ready;
            tick();
        end
        ar_valid = 1'b0;
        check("ar_handshake", 64'(fired), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic last);
        bit fired = 1'b0;
        w_data = data; w_strb = 4'hF; w_last = last;
        w_valid = 1'b1;
        for (int n = 0; n < 200 && !fired; n++) begin
            @(negedge clock);
            fired = w_ready;
            tick();
        end
        w_valid = 1'b0;
        check("w_handshake", 64'(fired), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge clock);
            idle = !busy;
        end
        check({tag, "_idle"}, 64'(idle), 64'd1);
        tick();
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, "_nflits"}, 64'(flits.size()), 64'(exp_q.size()));
        n = (flits.size() < exp_q.size()) ? flits.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_flit%0d", tag, i), 64'(flits[i]), 64'(exp_q[i]));
        flits.delete();
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        aw_valid = 0; ar_valid = 0; w_valid = 0; out_ready = 1;
        aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        w_data = 0; w_strb = 0; w_last = 0;
        aw_valid64 = 0; ar_valid64 = 0; w_valid64 = 0; out_ready64 = 1;
        aw_id64 = 0; aw_addr64 = 0; aw_len64 = 0; aw_size64 = 0; aw_burst64 = 0;
        ar_id64 = 0; ar_addr64 = 0; ar_len64 = 0; ar_size64 = 0; ar_burst64 = 0;
        w_data64 = 0; w_strb64 = 0; w_last64 = 0;

        // Reset state
        repeat (3) tick();
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_bits",  64'(out_bits),  0);
        check("rst_busy",      64'(busy),      0);
        check("rst_err",       64'(err_wlast), 0);
        check("rst_readies",   64'({aw_ready, ar_ready, w_ready}), 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: single-beat write, header one cycle after acceptance
        flits.delete(); err_cnt = 0;
        send_aw(4'd1, 32'h0, 8'd0, 3'd2);
        @(negedge clock);
        check("t1_hdr_valid", 64'(out_valid), 1);
        check("t1_hdr_bits",  64'(out_bits),  64'h0043_0000);
        send_w(32'h1111_1111, 1'b1);
        wait_idle("t1");
        exp_q = '{32'h0043_0000, 32'h0, 32'h0, 32'h1111_1111};
        compare_frame("t1");
        check("t1_err", 64'(err_cnt), 0);

        // 2: read, no data flits
        send_ar(4'd2, 32'h24, 8'd0, 3'd2);
        wait_idle("t2");
        exp_q = '{32'h0044_0000, 32'h0, 32'h24};
        compare_frame("t2");

        // 3: four-beat write burst
        err_cnt = 0;
        send_aw(4'd3, 32'h3000, 8'd3, 3'd2);
        send_w(32'hAABB_CCDD, 1'b0);
        send_w(32'h2222_2222, 1'b0);
        send_w(32'h3333_3333, 1'b0);
        send_w(32'h4444_4444, 1'b1);
        wait_idle("t3");
        exp_q = '{32'h0047_0003, 32'h0, 32'h3000,
                  32'hAABB_CCDD, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        compare_frame("t3");
        check("t3_err", 64'(err_cnt), 0);

        // 4a: collision just after reset -> write first
        do_reset();
        flits.delete();
        aw_id = 4'd5; aw_addr = 32'h100; aw_len = 0; aw_size = 3'd2; aw_valid = 1;
        ar_id = 4'd6; ar_addr = 32'h200; ar_len = 0; ar_size = 3'd2; ar_valid = 1;
        @(negedge clock);
        check("t4a_aw_ready", 64'(aw_ready), 1);
        check("t4a_ar_ready", 64'(ar_ready), 0);
        tick();
        aw_valid = 1'b0;
        send_w(32'h5555_5555, 1'b1);
        send_ar(4'd6, 32'h200, 8'd0, 3'd2);
        wait_idle("t4a");
        exp_q = '{32'h004B_0000, 32'h0, 32'h100, 32'h5555_5555,
                  32'h004C_0000, 32'h0, 32'h200};
        compare_frame("t4a");

        // 4b: back-pressure mid-data, bits held stable
        send_aw(4'd7, 32'h10, 8'd1, 3'd2);
        send_w(32'h0000_00A1, 1'b0);
        send_w(32'h0000_00B2, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("t4b_stall_valid%0d", i), 64'(out_valid), 1);
            check($sformatf("t4b_stall_bits%0d", i),  64'(out_bits),  64'hB2);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t4b");
        exp_q = '{32'h004F_0001, 32'h0, 32'h10, 32'hA1, 32'hB2};
        compare_frame("t4b");

        // 4c: collision after a write grant -> read wins
        aw_id = 4'd8; aw_addr = 32'h300; aw_len = 0; aw_size = 3'd2; aw_valid = 1;
        ar_id = 4'd9; ar_addr = 32'h400; ar_len = 0; ar_size = 3'd2; ar_valid = 1;
        @(negedge clock);
        check("t4c_ar_ready", 64'(ar_ready), 1);
        check("t4c_aw_ready", 64'(aw_ready), 0);
        tick();
        ar_valid = 1'b0;
        send_aw(4'd8, 32'h300, 8'd0, 3'd2);
        send_w(32'h6666_6666, 1'b1);
        wait_idle("t4c");
        exp_q = '{32'h0052_0000, 32'h0, 32'h400,
                  32'h0051_0000, 32'h0, 32'h300, 32'h6666_6666};
        compare_frame("t4c");

        // 5a: early w_last -> one pulse, still two beats framed
        err_cnt = 0;
        send_aw(4'd1, 32'h8, 8'd1, 3'd2);
        send_w(32'h0000_00C1, 1'b1);
        send_w(32'h0000_00C2, 1'b1);
        wait_idle("t5a");
        check("t5a_err", 64'(err_cnt), 1);
        exp_q = '{32'h0043_0001, 32'h0, 32'h8, 32'hC1, 32'hC2};
        compare_frame("t5a");

        // 5b: missing w_last on the final beat -> one pulse
        err_cnt = 0;
        send_aw(4'd2, 32'hC, 8'd0, 3'd2);
        send_w(32'h0000_00D1, 1'b0);
        wait_idle("t5b");
        check("t5b_err", 64'(err_cnt), 1);
        exp_q = '{32'h0045_0000, 32'h0, 32'hC, 32'hD1};
        compare_frame("t5b");

        // 5c: 64-bit data instance, one beat split into two flits
        begin
            bit fired = 1'b0;
            flits64.delete();
            aw_id64 = 4'd1; aw_addr64 = 32'h40; aw_len64 = 0; aw_size64 = 3'd3; aw_valid64 = 1;
            for (int n = 0; n < 200 && !fired; n++) begin
                @(negedge clock); fired = aw_ready64; tick();
            end
            aw_valid64 = 0;
            check("t5c_aw_handshake", 64'(fired), 1);
            fired = 1'b0;
            w_data64 = 64'h1122_3344_5566_7788; w_strb64 = 8'hFF; w_last64 = 1; w_valid64 = 1;
            for (int n = 0; n < 200 && !fired; n++) begin
                @(negedge clock); fired = w_ready64; tick();
            end
            w_valid64 = 0;
            check("t5c_w_handshake", 64'(fired), 1);
            fired = 1'b0;
            for (int n = 0; n < 200 && !fired; n++) begin
                @(negedge clock); fired = !busy64;
            end
            check("t5c_idle", 64'(fired), 1);
            check("t5c_nflits", 64'(flits64.size()), 5);
            if (flits64.size() == 5) begin
                check("t5c_hdr",   64'(flits64[0]), 64'h0063_0000);
                check("t5c_addr0", 64'(flits64[1]), 64'h0);
                check("t5c_addr1", 64'(flits64[2]), 64'h40);
                check("t5c_data0", 64'(flits64[3]), 64'h1122_3344);
                check("t5c_data1", 64'(flits64[4]), 64'h5566_7788);
            end
            tick();
        end

        // 6: reset mid-DATA aborts; pointer back to write
        send_aw(4'd4, 32'h20, 8'd0, 3'd2);
        send_w(32'h0000_0077, 1'b1);
        out_ready = 1'b0;
        tick();
        check("t6_busy_before", 64'(busy), 1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 0);
        check("t6_rst_bits",  64'(out_bits),  0);
        check("t6_rst_busy",  64'(busy),      0);
        check("t6_rst_wrdy",  64'(w_ready),   0);
        repeat (2) tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        flits.delete();
        aw_id = 4'd2; aw_addr = 32'h4; aw_len = 0; aw_size = 3'd2; aw_valid = 1;
        ar_id = 4'd3; ar_addr = 32'h8; ar_len = 0; ar_size = 3'd2; ar_valid = 1;
        @(negedge clock);
        check("t6_aw_ready", 64'(aw_ready), 1);
        check("t6_ar_ready", 64'(ar_ready), 0);
        tick();
        aw_valid = 1'b0;
        send_w(32'h0000_0099, 1'b1);
        send_ar(4'd3, 32'h8, 8'd0, 3'd2);
        wait_idle("t6");
        exp_q = '{32'h0045_0000, 32'h0, 32'h4, 32'h99,
                  32'h0046_0000, 32'h0, 32'h8};
        compare_frame("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
